// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings plus the small decode helpers used by the memory slave.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3
    } hsize_t;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'd0,
        HRESP_ERROR = 2'd1
    } hresp_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } mem_state_t;

    // Little-endian lane mask for a transfer of 2**size bytes starting at lane offset.
    function automatic logic [7:0] byte_enables(input logic [2:0] size, input logic [2:0] offset);
        logic [7:0] base;
        case (size)
            HSIZE_BYTE:  base = 8'h01;
            HSIZE_HALF:  base = 8'h03;
            HSIZE_WORD:  base = 8'h0F;
            HSIZE_DWORD: base = 8'hFF;
            default:     base = 8'h00;
        endcase
        return base << offset;
    endfunction

    function automatic logic misaligned(input logic [2:0] size, input logic [2:0] addr_lo);
        logic mis;
        case (size)
            HSIZE_BYTE:  mis = 1'b0;
            HSIZE_HALF:  mis = addr_lo[0];
            HSIZE_WORD:  mis = |addr_lo[1:0];
            HSIZE_DWORD: mis = |addr_lo;
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ahb_mem_array.sv
// DEPTH x dataWidth storage: one byte-enabled write port and one registered read port, no reset.
module ahb_mem_array #(
    parameter int unsigned dataWidth = 32,
    parameter int unsigned DEPTH     = 32,
    localparam int unsigned NB       = dataWidth / 8,
    localparam int unsigned IDX_W    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [IDX_W-1:0]     waddr,
    input  logic [NB-1:0]        wbe,
    input  logic [dataWidth-1:0] wdata,
    input  logic                 re,
    input  logic [IDX_W-1:0]     raddr,
    output logic [dataWidth-1:0] rdata
);

    logic [dataWidth-1:0] mem_q [DEPTH];
    logic [dataWidth-1:0] rdata_q;

    // Byte-lane write; lanes with a cleared enable keep their contents.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (wbe[b]) begin
                    mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Read register holds its value when no read is requested.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory slave: address-phase latch, legality check, wait/error FSM and
// write-to-read forwarding in front of ahb_mem_array.
module ahb_mem_slave
    import ahb_pkg::*;
#(
    parameter int unsigned addrWidth   = 8,
    parameter int unsigned dataWidth   = 32,
    parameter int unsigned DEPTH       = 32,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                 hclk,
    input  logic                 hreset,
    input  logic                 hselx,
    input  logic                 hready_in,
    input  logic [addrWidth-1:0] haddr,
    input  logic                 hwrite,
    input  logic [1:0]           htrans,
    input  logic [2:0]           hsize,
    input  logic [2:0]           hburst,
    input  logic [dataWidth-1:0] hwdata,
    output logic                 hready,
    output logic [1:0]           hresp,
    output logic [dataWidth-1:0] hrdata
);

    localparam int unsigned NB        = dataWidth / 8;
    localparam int unsigned OFFS_W    = $clog2(NB);
    localparam int unsigned IDX_W     = $clog2(DEPTH);
    localparam int unsigned MEM_BYTES = DEPTH * NB;

    mem_state_t           state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 hready_q, hready_d;
    hresp_t               hresp_q, hresp_d;
    logic                 dp_valid_q, dp_valid_d;
    logic                 dp_write_q, dp_write_d;
    logic [IDX_W-1:0]     dp_idx_q, dp_idx_d;
    logic [NB-1:0]        dp_be_q, dp_be_d;
    logic [NB-1:0]        fwd_be_q, fwd_be_d;
    logic [dataWidth-1:0] fwd_data_q, fwd_data_d;

    logic                 accept_s, legal_s, commit_s, phase_done_s;
    logic                 rd_now_s, rd_wait_s, re_s;
    logic [IDX_W-1:0]     idx_s, raddr_s;
    logic [NB-1:0]        be_s;
    logic [dataWidth-1:0] arr_rdata_s, hrdata_s;
    logic                 unused_hburst_s;

    assign unused_hburst_s = ^hburst;

    assign accept_s = hselx && hready_in && hready_q &&
                      (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
    // Upper address bits above the word index take part in the range check.
    assign legal_s  = (32'(haddr) < MEM_BYTES) &&
                      !misaligned(hsize, haddr[2:0]) &&
                      (32'(hsize) <= OFFS_W);
    assign idx_s    = haddr[OFFS_W +: IDX_W];
    assign be_s     = NB'(byte_enables(hsize, 3'(haddr[OFFS_W-1:0])));
    assign commit_s = dp_valid_q && dp_write_q && hready_q;

    // Zero-wait reads sample the array at accept; waited reads on the last stall edge.
    assign rd_now_s  = accept_s && legal_s && !hwrite && (WAIT_STATES == 32'd0);
    assign rd_wait_s = (state_q == ST_WAIT) && (cnt_q == 4'd1) && dp_valid_q && !dp_write_q;
    assign re_s      = rd_now_s || rd_wait_s;
    assign raddr_s   = rd_now_s ? idx_s : dp_idx_q;

    ahb_mem_array #(
        .dataWidth (dataWidth),
        .DEPTH     (DEPTH)
    ) u_array (
        .clk   (hclk),
        .we    (commit_s),
        .waddr (dp_idx_q),
        .wbe   (dp_be_q),
        .wdata (hwdata),
        .re    (re_s),
        .raddr (raddr_s),
        .rdata (arr_rdata_s)
    );

    // Data-phase FSM: wait countdown, two-cycle error, and next-transfer capture.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hready_d     = 1'b1;
        hresp_d      = HRESP_OKAY;
        dp_valid_d   = dp_valid_q;
        dp_write_d   = dp_write_q;
        dp_idx_d     = dp_idx_q;
        dp_be_d      = dp_be_q;
        phase_done_s = 1'b0;
        case (state_q)
            ST_IDLE, ST_ERR2: phase_done_s = 1'b1;
            ST_WAIT: begin
                if (cnt_q > 4'd1) begin
                    cnt_d    = cnt_q - 4'd1;
                    hready_d = 1'b0;
                end else if (cnt_q == 4'd1) begin
                    cnt_d = 4'd0;
                end else begin
                    phase_done_s = 1'b1;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
                hresp_d = HRESP_ERROR;
            end
            default: state_d = ST_IDLE;
        endcase
        if (phase_done_s) begin
            if (accept_s) begin
                dp_write_d = hwrite;
                dp_idx_d   = idx_s;
                dp_be_d    = be_s;
                if (legal_s) begin
                    dp_valid_d = 1'b1;
                    if (WAIT_STATES == 32'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d  = ST_WAIT;
                        cnt_d    = 4'(WAIT_STATES);
                        hready_d = 1'b0;
                    end
                end else begin
                    dp_valid_d = 1'b0;
                    state_d    = ST_ERR1;
                    hready_d   = 1'b0;
                    hresp_d    = HRESP_ERROR;
                end
            end else begin
                dp_valid_d = 1'b0;
                state_d    = ST_IDLE;
            end
        end else begin
            dp_valid_d = dp_valid_q;
        end
    end

    // Forwarding lanes: a read accepted while the previous write commits takes those lanes from hwdata.
    always_comb begin
        fwd_be_d   = fwd_be_q;
        fwd_data_d = fwd_data_q;
        if (re_s) begin
            fwd_data_d = hwdata;
            fwd_be_d   = (rd_now_s && commit_s && (dp_idx_q == idx_s)) ? dp_be_q : '0;
        end else begin
            fwd_be_d = fwd_be_q;
        end
    end

    // Registered state; reset selects all-forwarded zero data so hrdata reads 0.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            hready_q   <= 1'b1;
            hresp_q    <= HRESP_OKAY;
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_idx_q   <= '0;
            dp_be_q    <= '0;
            fwd_be_q   <= '1;
            fwd_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hready_q   <= hready_d;
            hresp_q    <= hresp_d;
            dp_valid_q <= dp_valid_d;
            dp_write_q <= dp_write_d;
            dp_idx_q   <= dp_idx_d;
            dp_be_q    <= dp_be_d;
            fwd_be_q   <= fwd_be_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    // Per-lane select between forwarded write data and the array read register.
    always_comb begin
        hrdata_s = '0;
        for (int b = 0; b < int'(NB); b++) begin
            hrdata_s[8*b +: 8] = fwd_be_q[b] ? fwd_data_q[8*b +: 8] : arr_rdata_s[8*b +: 8];
        end
    end

    assign hready = hready_q;
    assign hresp  = hresp_q;
    assign hrdata = hrdata_s;

endmodule
